// File: rtl/and_mux_pkg.sv
// Shared constants and types for the and_mux result-checking skid stage.
package and_mux_pkg;

  localparam int LANE_GOOD = 0;
  localparam int LANE_ONE  = 1;
  localparam int LANE_SWAP = 2;
  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // One buffered entry: lane results plus the golden a&b they are scored against.
  typedef struct packed {
    logic [NUM_LANES-1:0] y;
    logic                 golden;
  } result_t;

endpackage

// File: rtl/and_mux_result_skid_sat_counter.sv
// Saturating up-counter with a synchronous clear that can coincide with an increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      // The event that arrives alongside the clear still counts.
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/and_mux_result_skid.sv
// Scores three and_mux lane results against golden a&b and forwards them
// through a 2-entry skid buffer with per-lane saturating mismatch counters.
module and_mux_result_skid
  import and_mux_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic [2:0]       in_y,
  input  logic             cnt_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_y,
  output logic             out_ref,
  output logic [2:0]       out_mis,
  output logic [CNT_W-1:0] err_cnt_good,
  output logic [CNT_W-1:0] err_cnt_one,
  output logic [CNT_W-1:0] err_cnt_swap
);

  skid_state_t state_q, state_d;
  result_t     main_q, main_d;
  result_t     skid_q, skid_d;
  logic        in_ready_q, in_ready_d;

  logic                 accept;
  logic                 pop;
  result_t              entry;
  logic [NUM_LANES-1:0] lane_inc;
  logic [CNT_W-1:0]     lane_cnt [NUM_LANES];

  assign accept       = in_valid & in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign pop          = out_valid & out_ready;
  assign entry.y      = in_y;
  assign entry.golden = in_a & in_b;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          skid_d  = entry;
          state_d = ST_FULL;
        end else if (accept && pop) begin
          main_d  = entry;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can move the buffer.
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_y    = main_q.y;
  assign out_ref  = main_q.golden;
  assign out_mis  = main_q.y ^ {NUM_LANES{main_q.golden}};

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_inc[gi] = accept & (in_y[gi] != entry.golden);

      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (lane_inc[gi]),
        .cnt   (lane_cnt[gi])
      );
    end
  endgenerate

  assign err_cnt_good = lane_cnt[LANE_GOOD];
  assign err_cnt_one  = lane_cnt[LANE_ONE];
  assign err_cnt_swap = lane_cnt[LANE_SWAP];

endmodule
